// File: rtl/sram_pkg.sv
// Shared definitions for the 64x8 single-port SRAM initiator controller.
package sram_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    // SRAM rw pin polarity: high = read (SRAM owns the bus), low = write
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_R_ADDR = 3'd1,
        ST_R_DATA = 3'd2,
        ST_W_TURN = 3'd3,
        ST_W_EXEC = 3'd4,
        ST_W_REL  = 3'd5
    } state_t;

endpackage

// File: rtl/sram_bus_io.sv
// Tristate buffer for the shared SRAM data bus; keeps the inout pin handling in one place.
module sram_bus_io #(
    parameter int DATA_W = 8
) (
    input  logic              drive_en_i,
    input  logic [DATA_W-1:0] data_out_i,
    output logic [DATA_W-1:0] data_in_o,
    inout  wire  [DATA_W-1:0] pad_io
);

    assign pad_io    = drive_en_i ? data_out_i : {DATA_W{1'bz}};
    assign data_in_o = pad_io;

endmodule

// File: rtl/sram_controller.sv
// Initiator-side controller for a single-port SRAM with a shared data bus.
// Every SRAM-side output and the bus drive enable come straight from flops.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | ce=0 rw=1, SRAM owns the bus, ready for a request
//   ST_R_ADDR | ce=1 rw=1, SRAM registers the read address
//   ST_R_DATA | ce=0 rw=1, bus sampled into o_rdata at end of cycle
//   ST_W_TURN | ce=0 rw=0, turnaround, SRAM releases the bus
//   ST_W_EXEC | ce=1 rw=0, controller drives write data, SRAM writes
//   ST_W_REL  | ce=0 rw=0, controller releases bus, o_wdone pulses
module sram_controller
    import sram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_wdone,
    output logic              o_sram_ce,
    output logic              o_sram_rw,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [DATA_W-1:0] io_sram_data
);

    state_t              state_q, state_d;
    logic                sram_ce_q, sram_ce_d;
    logic                sram_rw_q, sram_rw_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic                drive_en_q, drive_en_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                wdone_q, wdone_d;
    logic [DATA_W-1:0]   bus_in;

    sram_bus_io #(.DATA_W(DATA_W)) u_bus_io (
        .drive_en_i (drive_en_q),
        .data_out_i (wdata_q),
        .data_in_o  (bus_in),
        .pad_io     (io_sram_data)
    );

    // Next state plus the registered pin values that belong to the state being entered
    always_comb begin
        state_d     = state_q;
        sram_ce_d   = 1'b0;
        sram_rw_d   = RW_READ;
        sram_addr_d = sram_addr_q;
        drive_en_d  = 1'b0;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        wdone_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    sram_addr_d = i_addr;
                    wdata_d     = i_wdata;
                    if (i_rw == RW_READ) begin
                        state_d   = ST_R_ADDR;
                        sram_ce_d = 1'b1;
                    end else begin
                        state_d   = ST_W_TURN;
                        sram_rw_d = RW_WRITE;
                    end
                end
            end
            ST_R_ADDR: begin
                state_d = ST_R_DATA;
            end
            ST_R_DATA: begin
                state_d  = ST_IDLE;
                rdata_d  = bus_in;
                rvalid_d = 1'b1;
            end
            ST_W_TURN: begin
                state_d    = ST_W_EXEC;
                sram_ce_d  = 1'b1;
                sram_rw_d  = RW_WRITE;
                drive_en_d = 1'b1;
            end
            ST_W_EXEC: begin
                // Bus is released here while rw stays low for one more cycle
                state_d   = ST_W_REL;
                sram_rw_d = RW_WRITE;
                wdone_d   = 1'b1;
            end
            ST_W_REL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                sram_addr_d = '0;
                rdata_d     = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            sram_ce_q   <= 1'b0;
            sram_rw_q   <= RW_READ;
            sram_addr_q <= '0;
            drive_en_q  <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            wdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sram_ce_q   <= sram_ce_d;
            sram_rw_q   <= sram_rw_d;
            sram_addr_q <= sram_addr_d;
            drive_en_q  <= drive_en_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            wdone_q     <= wdone_d;
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_rdata     = rdata_q;
    assign o_rvalid    = rvalid_q;
    assign o_wdone     = wdone_q;
    assign o_sram_ce   = sram_ce_q;
    assign o_sram_rw   = sram_rw_q;
    assign o_sram_addr = sram_addr_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural 64x8 SRAM on the shared bus.
module tb_sram_controller;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready, rvalid, wdone, sce, srw;
    logic [AW-1:0] saddr;
    logic [DW-1:0] rdata;
    wire  [DW-1:0] sbus;

    always #5 clk = ~clk;

    sram_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req        (req),
        .i_rw         (rw),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_ready      (ready),
        .o_rdata      (rdata),
        .o_rvalid     (rvalid),
        .o_wdone      (wdone),
        .o_sram_ce    (sce),
        .o_sram_rw    (srw),
        .o_sram_addr  (saddr),
        .io_sram_data (sbus)
    );

    // SRAM model: write on ce&!rw, register read address on ce&rw, drive bus whenever rw=1
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] mem_raddr;
    logic          mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
            mem_raddr <= '0;
        end else begin
            if (sce && !srw) mem[saddr] <= sbus;
            if (sce && srw)  mem_raddr  <= saddr;
        end
    end

    assign sbus = srw ? mem[mem_raddr] : {DW{1'bz}};

    // Transaction-level reference: memory contents plus age of the last accepted request
    logic [DW-1:0] ref_mem [2**AW];
    int            m_kind;   // 0 none, 1 read, 2 write
    int            m_age;    // cycles since the accept edge
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_pend, m_rdata;
    logic          prev_srw;
    int            n_checks, n_errors, ce_seen, n_accept;

    typedef struct {
        logic          req;
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [12:0]   exp;   // {ready, rvalid, wdone, ce, sram_rw, rdata}
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic r, input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic e_rdy, input logic e_rv,
                                input logic e_wd, input logic e_ce, input logic e_rw,
                                input logic [DW-1:0] e_rd);
        vec_t v;
        v.req = r; v.rw = w; v.a = a; v.d = d;
        v.exp = {e_rdy, e_rv, e_wd, e_ce, e_rw, e_rd};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs of the current cycle, apply inputs, advance the model
    task automatic do_cycle(input logic r_rst, input logic r_req, input logic r_rw,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic e_ready, e_rv, e_wd, e_ce, e_rw, e_de, de, acc;
        e_ready = (m_kind == 0) || (m_kind == 1 && m_age >= 3) || (m_kind == 2 && m_age >= 4);
        e_rv    = (m_kind == 1 && m_age == 3);
        e_wd    = (m_kind == 2 && m_age == 3);
        e_ce    = (m_kind == 1 && m_age == 1) || (m_kind == 2 && m_age == 2);
        e_rw    = !(m_kind == 2 && m_age >= 1 && m_age <= 3);
        e_de    = (m_kind == 2 && m_age == 2);
        de      = dut.drive_en_q;
        chk("cycle", {ready, rvalid, wdone, sce, srw, de, rdata},
                     {e_ready, e_rv, e_wd, e_ce, e_rw, e_de, m_rdata});
        if (e_ce) chk("sram_addr", saddr, m_addr);
        if (e_de) chk("bus_wdata", sbus, m_wd);
        chk("no_contention", {de && (srw || prev_srw), de && $isunknown(sbus)}, 2'b00);
        if (sce) ce_seen++;
        prev_srw = srw;

        rst = r_rst; req = r_req; rw = r_rw; addr = a; wdata = d;
        acc = !r_rst && r_req && e_ready;
        if (acc) begin
            n_accept++;
            m_kind = r_rw ? 1 : 2;
            m_age  = 0;
            m_addr = a;
            m_wd   = d;
            if (r_rw) m_pend = ref_mem[a];
            else      ref_mem[a] = d;
        end
        @(posedge clk);
        if (r_rst) begin
            m_kind  = 0;
            m_age   = 0;
            m_rdata = '0;
        end else begin
            if (m_age < 15) m_age++;
            if (m_kind == 1 && m_age == 3) m_rdata = m_pend;
        end
        @(negedge clk);
    endtask

    initial begin
        int base_ce, base_acc;
        n_checks = 0; n_errors = 0; ce_seen = 0; n_accept = 0;
        m_kind = 0; m_age = 0; m_addr = '0; m_wd = '0; m_pend = '0; m_rdata = '0;
        prev_srw = 1'b1;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;

        tbl[0]  = mk(1, 0, 6'h05, 8'hA5, 1, 0, 0, 0, 1, 8'h00);
        tbl[1]  = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        tbl[2]  = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00);
        tbl[3]  = mk(0, 0, 6'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00);
        tbl[4]  = mk(1, 1, 6'h05, 8'h00, 1, 0, 0, 0, 1, 8'h00);
        tbl[5]  = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 1, 8'h00);
        tbl[6]  = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        tbl[7]  = mk(1, 0, 6'h3F, 8'h81, 1, 1, 0, 0, 1, 8'hA5);
        tbl[8]  = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[9]  = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 0, 8'hA5);
        tbl[10] = mk(0, 0, 6'h00, 8'h00, 0, 0, 1, 0, 0, 8'hA5);
        tbl[11] = mk(1, 0, 6'h00, 8'h7E, 1, 0, 0, 0, 1, 8'hA5);
        tbl[12] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[13] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 0, 8'hA5);
        tbl[14] = mk(0, 0, 6'h00, 8'h00, 0, 0, 1, 0, 0, 8'hA5);
        tbl[15] = mk(1, 1, 6'h3F, 8'h00, 1, 0, 0, 0, 1, 8'hA5);
        tbl[16] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 1, 8'hA5);
        tbl[17] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 1, 8'hA5);
        tbl[18] = mk(1, 1, 6'h00, 8'h00, 1, 1, 0, 0, 1, 8'h81);
        tbl[19] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 1, 8'h81);
        tbl[20] = mk(0, 0, 6'h00, 8'h00, 0, 0, 0, 0, 1, 8'h81);
        tbl[21] = mk(0, 0, 6'h00, 8'h00, 1, 1, 0, 0, 1, 8'h7E);
        tbl[22] = mk(0, 0, 6'h00, 8'h00, 1, 0, 0, 0, 1, 8'h7E);

        // Reset with SRAM contents cleared
        rst = 1'b1; req = 1'b0; rw = 1'b1; addr = '0; wdata = '0; mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        chk("reset_addr", saddr, 0);
        chk("reset_pins", {sce, srw, dut.drive_en_q, rvalid, wdone, rdata}, {5'b01000, 8'h00});

        // Directed table: basic write/read, boundary addresses, back-to-back read on rvalid
        for (int i = 0; i < 23; i++) begin
            chk($sformatf("vec%0d", i), {ready, rvalid, wdone, sce, srw, rdata}, tbl[i].exp);
            do_cycle(1'b0, tbl[i].req, tbl[i].rw, tbl[i].a, tbl[i].d);
        end

        // Request held high with changing address while busy: only ready-cycle samples run
        base_ce = ce_seen; base_acc = n_accept;
        for (int i = 0; i < 16; i++)
            do_cycle(1'b0, 1'b1, (i % 3) != 0, 6'(i * 5 + 1), 8'(8'h30 + i));
        repeat (5) do_cycle(1'b0, 1'b0, 1'b1, '0, '0);
        chk("ce_per_accept", ce_seen - base_ce, n_accept - base_acc);

        // Reset during W_EXEC: write still commits, no wdone
        do_cycle(1'b0, 1'b1, 1'b0, 6'h10, 8'h55);
        do_cycle(1'b0, 1'b0, 1'b1, '0, '0);
        do_cycle(1'b1, 1'b0, 1'b1, '0, '0);
        chk("rst_wexec_pins", {sce, srw, dut.drive_en_q, wdone}, 4'b0100);
        do_cycle(1'b0, 1'b0, 1'b1, '0, '0);
        chk("rst_wexec_no_wdone", wdone, 0);
        do_cycle(1'b0, 1'b1, 1'b1, 6'h10, '0);
        do_cycle(1'b0, 1'b0, 1'b1, '0, '0);
        do_cycle(1'b0, 1'b0, 1'b1, '0, '0);
        chk("rst_write_commit", {rvalid, rdata}, {1'b1, 8'h55});
        do_cycle(1'b0, 1'b0, 1'b1, '0, '0);

        // Reset during R_ADDR: no rvalid, rdata cleared, ready back
        do_cycle(1'b0, 1'b1, 1'b1, 6'h05, '0);
        do_cycle(1'b1, 1'b0, 1'b1, '0, '0);
        do_cycle(1'b0, 1'b0, 1'b1, '0, '0);
        chk("rst_raddr_out", {rvalid, rdata, ready}, {1'b0, 8'h00, 1'b1});
        repeat (3) do_cycle(1'b0, 1'b0, 1'b1, '0, '0);

        // Randomized traffic, biased toward the boundary addresses
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra;
            case ($urandom_range(0, 3))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = AW'($urandom_range(0, 2**AW - 1));
            endcase
            do_cycle(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra,
                     DW'($urandom_range(0, 255)));
        end
        repeat (5) do_cycle(1'b0, 1'b0, 1'b1, '0, '0);
        chk("ce_total", ce_seen, n_accept);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Initiator-side controller for the 64x8 single-port SRAM with a shared bidirectional data bus. It accepts single-word read/write requests from a user-side valid/ready handshake and sequences the SRAM control signals. It owns bus turnaround so the controller and SRAM never drive io_sram_data at the same time. It returns read data with a one-cycle valid pulse. It sits between system logic (CPU/UART/test FSM) and the staticRAM instance.

Parameters:
ADDR_W, 6, SRAM address width (depth 2^ADDR_W).
DATA_W, 8, SRAM data width.

Ports:
i_clk  input  1  system clock; all logic on posedge.
i_reset  input  1  synchronous, active-high reset.
i_req  input  1  user request valid.
i_rw  input  1  request type: 1 = read, 0 = write (same polarity as the SRAM).
i_addr  input  ADDR_W  request address.
i_wdata  input  DATA_W  write data.
o_ready  output  1  controller can accept a request this cycle.
o_rdata  output  DATA_W  read data; held until the next read completes.
o_rvalid  output  1  one-cycle pulse; o_rdata is valid.
o_wdone  output  1  one-cycle pulse; write committed to SRAM.
o_sram_ce  output  1  SRAM chip enable.
o_sram_rw  output  1  SRAM read/write select.
o_sram_addr  output  ADDR_W  SRAM address.
io_sram_data  inout  DATA_W  shared data bus; driven only while internal drive enable = 1, else Z.

Behaviour:
- Clocking and reset: single clock i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: state = IDLE, o_sram_ce = 0, o_sram_rw = 1, o_sram_addr = 0, drive enable = 0 (bus Z), o_rdata = 0, o_rvalid = 0, o_wdone = 0.
- Registered outputs: all SRAM-side outputs and the drive enable are registered. There is no combinational path from user inputs to SRAM pins.
- SRAM contract:
  - The SRAM captures the write on the posedge where ce = 1 and rw = 0.
  - It registers the read address on the posedge where ce = 1 and rw = 1.
  - It drives the bus combinationally whenever rw = 1, regardless of ce.
- Idle bus state: o_sram_rw = 1 (SRAM owns the bus, so it never floats).
- Accept rule: a request is accepted on the posedge where i_req & o_ready. i_addr, i_wdata and i_rw are latched at that edge. o_ready = 1 only in IDLE. i_req while busy is ignored (not queued).
- IDLE: ce = 0, rw = 1, drive enable = 0.
  - Accept read -> R_ADDR.
  - Accept write -> W_TURN.
- R_ADDR: ce = 1, rw = 1, addr = latched. SRAM registers the address at the end of this cycle -> R_DATA.
- R_DATA: ce = 0, rw = 1. io_sram_data is sampled into o_rdata at the end of this cycle -> IDLE with o_rvalid = 1 for one cycle.
- W_TURN: ce = 0, rw = 0, drive enable = 0. This is the turnaround cycle that lets the SRAM release the bus -> W_EXEC.
- W_EXEC: ce = 1, rw = 0, addr = latched, drive enable = 1, bus = latched wdata. The SRAM writes at the end of this cycle -> W_REL.
- W_REL: ce = 0, rw = 0, drive enable = 0 (bus released before rw returns to 1). o_wdone = 1 in this cycle -> IDLE.
- Latency:
  - Read: o_rvalid is asserted 3 edges after the accept edge; o_ready is low for 2 cycles.
  - Write: o_wdone is asserted 3 edges after the accept edge; o_ready is low for 3 cycles.
- Back-to-back: a new request may be accepted in the IDLE cycle that carries o_rvalid. Sustained throughput is one read per 3 cycles and one write per 4 cycles.
- Invariant: drive enable = 1 implies o_sram_rw = 0 and the previous-cycle o_sram_rw = 0. The bus never has two drivers.
- Address: passed through unmodified. Address 2^ADDR_W-1 is legal; there is no wrap or increment.
- Reset mid-operation: the next edge forces the reset values. A write cut off in W_EXEC has already been presented to the SRAM in that cycle, so it commits. o_wdone is not generated for it, and o_rvalid is not generated for a cut-off read.
- Unknown state: fall back to IDLE with reset outputs.

Decomposition:
- Shared package sram_pkg holds:
  - state encoding constants ST_IDLE, ST_R_ADDR, ST_R_DATA, ST_W_TURN, ST_W_EXEC, ST_W_REL;
  - RW_READ = 1, RW_WRITE = 0;
  - default ADDR_W / DATA_W.
- One sub-module, sram_bus_io: the tristate buffer (drive enable, out data, in data, inout pin). It keeps the inout handling isolated and reusable.

Test Plan:
- Reset, then write addr 0x05 data 0xA5, then read addr 0x05 -> o_wdone on the 3rd edge after accept; o_rvalid on the 3rd edge after the read accept with o_rdata = 0xA5.
- Write 0x3F = 0x81 and 0x00 = 0x7E, then read both -> 0x81, 0x7E (boundary addresses, no aliasing).
- Read accepted in the same cycle as the previous o_rvalid -> second read completes 3 cycles later. Every cycle, assert never (drive enable & o_sram_rw), and assert the bus is never X while drive enable = 1.
- Hold i_req = 1 with changing i_addr while busy -> only requests sampled with o_ready = 1 are executed; the SRAM sees exactly one ce pulse per accepted request.
- Assert i_reset during W_EXEC for addr 0x10 data 0x55 -> next cycle ce = 0, rw = 1, bus Z, no o_wdone; a subsequent read of 0x10 returns 0x55.
- Assert i_reset during R_ADDR -> no o_rvalid, o_rdata = 0, o_ready = 1 in the cycle after reset deasserts.
